// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-organised data memory slave with a req/gnt request channel and an
//   in-order rvalid response channel. Accepted transactions are answered a
//   fixed LATENCY cycles later; at most MAX_OUTST may be awaiting an answer.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words stored
//   BASE_ADDR   : byte address of word 0
//   LATENCY     : cycles from accept edge to rvalid_o (1..4)
//   MAX_OUTST   : accepted transactions allowed without a response (1..4)
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (memory contents kept)
//   req_i    in   request
//   gnt_o    out  request granted this cycle (combinational)
//   we_i     in   1 = write, 0 = read
//   be_i     in   byte enables for writes
//   addr_i   in   byte address (bits [1:0] ignored)
//   wdata_i  in   write data
//   rvalid_o out  one-cycle response strobe
//   rdata_o  out  read data (0 for writes / errors / idle)
//   err_o    out  address out of range (qualified by rvalid_o)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned MAX_OUTST   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One past the last valid byte, held in 33 bits so the upper bound
  // cannot wrap around for windows ending at the top of the address space.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [2:0]         r_cnt;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_dat [LATENCY];

  logic               w_acc;
  logic               w_inrange;
  logic [AW-1:0]      w_idx;

  always_comb begin
    gnt_o     = req_i && (r_cnt < 3'(MAX_OUTST)) && !rst_i;
    w_acc     = gnt_o;
    w_inrange = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < END_ADDR);
    w_idx     = AW'((addr_i - BASE_ADDR) >> 2);
    rvalid_o  = r_vld[LATENCY-1];
    rdata_o   = r_dat[LATENCY-1];
    err_o     = r_err[LATENCY-1];
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (w_acc && we_i && w_inrange) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Response pipeline: stage 0 is loaded at the accept edge, the last stage
  // drives the outputs. Data/err stages carry zero whenever valid is low, so
  // the outputs are clean without extra gating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_vld <= '0;
      r_err <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc && !w_inrange;
      r_dat[0] <= (w_acc && !we_i && w_inrange) ? r_mem[w_idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      // A retiring response only frees its slot from the next cycle on,
      // because gnt_o is computed from the registered count.
      unique case ({w_acc, rvalid_o})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct {
    int unsigned due;
    logic [31:0] d;
    logic [31:0] m;
    logic        e;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  gn;
  logic [2:0]  rv;
  logic [2:0]  er;
  logic [31:0] rd [3];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Three configurations share one stimulus stream; each has its own model.
  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int unsigned LAT  = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    localparam int unsigned MO   = (gi == 2) ? 3 : 2;
    localparam int unsigned DEP  = (gi == 2) ? 32 : 64;
    localparam logic [31:0] BASE = (gi == 2) ? 32'h100 : 32'h0;

    dmem_responder #(
      .DEPTH_WORDS(DEP),
      .BASE_ADDR  (BASE),
      .LATENCY    (LAT),
      .MAX_OUTST  (MO)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .gnt_o   (gn[gi]),
      .we_i    (we),
      .be_i    (be),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rvalid_o(rv[gi]),
      .rdata_o (rd[gi]),
      .err_o   (er[gi])
    );

    logic [31:0] m_mem   [DEP];
    bit   [3:0]  m_known [DEP];
    resp_t       q[$];
    int unsigned cnt_m = 0;

    always @(negedge clk) begin : model
      resp_t           h;
      logic            exp_v;
      logic            exp_g;
      logic            inr;
      longint unsigned a;
      int unsigned     idx;
      if (rst) begin
        chk($sformatf("u%0d.rst.rvalid", gi), 32'(rv[gi]), 32'd0);
        chk($sformatf("u%0d.rst.rdata", gi), rd[gi], 32'd0);
        chk($sformatf("u%0d.rst.err", gi), 32'(er[gi]), 32'd0);
        chk($sformatf("u%0d.rst.gnt", gi), 32'(gn[gi]), 32'd0);
        q.delete();
        cnt_m = 0;
      end else begin
        exp_v = (q.size() != 0) && (q[0].due == cyc);
        if (exp_v) h = q.pop_front();
        else h = '{due: 0, d: 32'h0, m: 32'hFFFF_FFFF, e: 1'b0};
        chk($sformatf("u%0d.rvalid", gi), 32'(rv[gi]), 32'(exp_v));
        chk($sformatf("u%0d.rdata", gi), rd[gi] & h.m, h.d & h.m);
        chk($sformatf("u%0d.err", gi), 32'(er[gi]), 32'(h.e));
        exp_g = req && (cnt_m < MO);
        chk($sformatf("u%0d.gnt", gi), 32'(gn[gi]), 32'(exp_g));
        if (exp_g) begin
          a   = 64'(addr);
          inr = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(DEP) * 4);
          idx = inr ? int'((a - 64'(BASE)) >> 2) : 0;
          h   = '{due: cyc + LAT, d: 32'h0, m: 32'hFFFF_FFFF, e: !inr};
          if (inr && !we) begin
            h.d = m_mem[idx];
            for (int k = 0; k < 4; k++) h.m[8*k +: 8] = m_known[idx][k] ? 8'hFF : 8'h00;
          end
          if (inr && we) begin
            for (int k = 0; k < 4; k++) begin
              if (be[k]) begin
                m_mem[idx][8*k +: 8] = wdata[8*k +: 8];
                m_known[idx][k] = 1'b1;
              end
            end
          end
          q.push_back(h);
          cnt_m++;
        end
        if (exp_v) cnt_m--;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // n = number of sampling points until the response (0 = no response within 12 samples).
  task automatic wait_rv(input int idx, output int n, output logic [31:0] d, output logic e);
    n = 0; d = '0; e = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rv[idx]) begin
        n = c; d = rd[idx]; e = er[idx];
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] d;
    logic        e;
    logic [15:0] pat;
    logic [15:0] rpat;
    int          k;
    int          nr;
    logic [31:0] edge_addr [4];

    rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset holds grants low even with req high; first edge after release accepts.
    repeat (2) @(negedge clk);
    chk("rst.gnt_all", 32'(gn), 32'd0);
    chk("rst.rvalid_all", 32'(rv), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel.gnt_all", 32'(gn), 32'h7);
    @(posedge clk); #1; req = 1'b0;
    idle(6);

    // Single write then read, LATENCY=1 instance.
    issue(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    wait_rv(0, n, d, e);
    chk("wr.lat", n, 1); chk("wr.rdata", d, 32'h0); chk("wr.err", 32'(e), 0);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    wait_rv(0, n, d, e);
    chk("rd.lat", n, 1); chk("rd.rdata", d, 32'hDEAD_BEEF); chk("rd.err", 32'(e), 0);

    // Byte enables.
    issue(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    wait_rv(0, n, d, e);
    issue(1'b1, 4'b0101, 32'h22, 32'hAABB_CCDD);
    wait_rv(0, n, d, e);
    issue(1'b0, 4'hF, 32'h21, 32'h0);
    wait_rv(0, n, d, e);
    chk("be.rdata", d, 32'h11BB_33DD);

    // Out-of-range write at BASE + 4*DEPTH leaves word 0 alone.
    issue(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D);
    wait_rv(0, n, d, e);
    issue(1'b1, 4'hF, 32'h100, 32'hFFFF_FFFF);
    wait_rv(0, n, d, e);
    chk("oor.err", 32'(e), 1); chk("oor.rdata", d, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    wait_rv(0, n, d, e);
    chk("oor.word0", d, 32'h0BAD_F00D); chk("oor.word0_err", 32'(e), 0);
    idle(8);

    // Backpressure on the LATENCY=3 / MAX_OUTST=2 instance.
    for (int j = 0; j < 4; j++) begin
      issue(1'b1, 4'hF, 32'h40 + 32'(4 * j), 32'hB000_0000 + 32'(j));
      idle(4);
    end
    idle(4);
    pat = '0; rpat = '0; k = 0; nr = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h40;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gn[1]) begin pat[c] = 1'b1; k++; end
      if (rv[1]) begin
        rpat[c] = 1'b1;
        chk("bp.rdata", rd[1], 32'hB000_0000 + 32'(nr));
        nr++;
      end
      @(posedge clk); #1;
      addr = 32'h40 + 32'(4 * k);
      if (k >= 4) req = 1'b0;
    end
    chk("bp.grants", 32'(pat[5:0]), 32'b110011);
    chk("bp.rvalids", 32'(rpat), 32'h0198);
    chk("bp.count", nr, 4);
    idle(8);

    // Reset mid-flight on the LATENCY=2 instance (window 0x100..0x17F).
    issue(1'b1, 4'hF, 32'h140, 32'hCAFE_F00D);
    idle(6);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h140;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid.cnt", 32'(g_inst[2].u_dut.r_cnt), 32'd0);
    chk("mid.rvalid", 32'(rv[2]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h140;
    @(negedge clk);
    chk("mid.gnt_after", 32'(gn[2]), 32'd1);
    chk("mid.no_stale", 32'(rv[2]), 32'd0);
    @(posedge clk); #1; req = 1'b0;
    wait_rv(2, n, d, e);
    chk("mid.lat", n, 2); chk("mid.rdata", d, 32'hCAFE_F00D); chk("mid.err", 32'(e), 0);
    nr = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv[2]) nr++;
    end
    chk("mid.extra_rvalid", nr, 0);

    // Randomised traffic with occasional resets and window-edge addresses.
    edge_addr[0] = 32'h0FC; edge_addr[1] = 32'h100;
    edge_addr[2] = 32'h17C; edge_addr[3] = 32'h180;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      req   = ($urandom_range(0, 9) < 7);
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       addr = $urandom;
        1:       addr = 32'hFFFF_FFFC;
        2:       addr = edge_addr[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
        default: addr = 32'($urandom_range(0, 32'h1BF));
      endcase
    end
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    idle(10);
    @(negedge clk);
    chk("end.q0_empty", g_inst[0].q.size(), 0);
    chk("end.q1_empty", g_inst[1].q.size(), 0);
    chk("end.q2_empty", g_inst[2].q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 1: number of cycles from accept edge to rvalid_o, legal range 1..4.
REQ-004 SHALL have parameter MAX_OUTST, default 2: maximum number of accepted transactions awaiting a response, legal range 1..4.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_i, input, 1 bit: initiator request.
REQ-008 SHALL have port gnt_o, output, 1 bit: request granted this cycle.
REQ-009 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port be_i, input, 4 bits: byte enables for writes.
REQ-011 SHALL have port addr_i, input, 32 bits: byte address.
REQ-012 SHALL have port wdata_i, input, 32 bits: write data.
REQ-013 SHALL have port rvalid_o, output, 1 bit: response valid, one cycle per transaction.
REQ-014 SHALL have port rdata_o, output, 32 bits: read data, qualified by rvalid_o.
REQ-015 SHALL have port err_o, output, 1 bit: address error, qualified by rvalid_o.

Function
REQ-016 SHALL drive gnt_o combinationally as req_i AND (cnt < MAX_OUTST) AND NOT rst_i.
- cnt is the number of accepted transactions not yet responded to.
- A response retiring in the same cycle SHALL NOT free a slot for that cycle.
REQ-017 SHALL accept a transaction on a rising edge where req_i and gnt_o are both high; at most one per cycle.
REQ-018 SHALL compute the word index as (addr_i - BASE_ADDR) >> 2; addr_i[1:0] is ignored.
REQ-019 SHALL flag a transaction in range when BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH_WORDS, using unsigned 32-bit compares, with no wrap-around.
REQ-020 SHALL, on an accepted in-range write, update byte k of the addressed word from wdata_i[8k+7:8k] only where be_i[k]=1, at the accept edge.
REQ-021 SHALL, on an accepted in-range read, capture the word at the accept edge.
- The captured value includes all writes accepted on earlier edges.
- be_i is ignored for reads.
REQ-022 SHALL NOT modify memory for an out-of-range access.
REQ-023 SHALL assert rvalid_o for exactly one cycle, in the cycle beginning LATENCY edges after the accept edge.
- Responses SHALL be in acceptance order.
- Back-to-back accepts SHALL produce back-to-back responses.
REQ-024 SHALL, with rvalid_o, drive rdata_o with the following values:
- in-range read: the captured word;
- write: 32'h0;
- out-of-range access: 32'h0.
REQ-025 SHALL assert err_o with rvalid_o only for out-of-range accesses.
REQ-026 SHALL hold rdata_o = 0 and err_o = 0 whenever rvalid_o = 0.
REQ-027 SHALL update cnt as follows: +1 on accept, -1 on rvalid_o, unchanged when both occur in the same cycle; cnt SHALL never exceed MAX_OUTST or go below 0.
REQ-028 SHALL implement the response path as a LATENCY-stage valid/rdata/err shift pipeline; no other state machine is needed.

Reset
REQ-029 SHALL, while rst_i is high, force gnt_o = 0, rvalid_o = 0, rdata_o = 0, err_o = 0 and cnt = 0, with all pipeline stages cleared asynchronously.
REQ-030 SHALL discard responses in flight when reset is asserted mid-operation; none SHALL appear after reset is released.
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL accept a request on the first rising edge after rst_i deasserts, provided req_i is high.

Verification
REQ-033 Single write/read, LATENCY=1:
- Stimulus: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10.
- Response: write rvalid 1 cycle after its accept with rdata=0; read rvalid 1 cycle after its accept with rdata=0xDEADBEEF, err=0.
REQ-034 Byte enables:
- Stimulus: word 0x20 = 0x11223344; write 0xAABBCCDD with be=4'b0101; read 0x20.
- Response: rdata=0x11BB33DD.
REQ-035 Backpressure, LATENCY=3, MAX_OUTST=2:
- Stimulus: req_i held high for 4 reads.
- Response: grants on cycles 0 and 1; no grant on cycles 2 and 3; grants resume only after a retirement; 4 in-order rvalids.
REQ-036 Out of range:
- Stimulus: write to BASE_ADDR + 4*DEPTH_WORDS, then read word 0.
- Response: write rvalid with err=1 and rdata=0; word 0 unchanged.
REQ-037 Reset mid-operation, LATENCY=2:
- Stimulus: accept a read, then assert rst_i for 1 cycle before its response.
- Response: no rvalid ever appears for it; cnt=0; next request granted on the first edge after rst_i falls; prior memory contents intact.
